dcj11_bus_sync: RTL and testbench

Synchronous front end for the DCJ11 bus: samples the asynchronous ALE_n, SCTL_n, BUFCTL_n strobes and DAL/AIO lines in the sys_clk domain. Turns each bus cycle into clean single-cycle events: cycle start, read request, and write request with data and byte enables. Sits directly upstream of the memory and memory-mapped I/O logic (console UART registers, power-up configuration read), replacing edge-clocked latching with one-clock-domain strobes.

---
 rtl/dcj11_bus_sync_pkg.sv | 48 ++++
 rtl/dcj11_bus_sync_sync_edge.sv | 34 +++
 rtl/dcj11_bus_sync.sv | 245 ++++++++++++++++++++++++
 tb/tb_dcj11_bus_sync.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcj11_bus_sync_pkg.sv
// Shared definitions for the DCJ11 bus front end: AIO codes, cycle kinds,
// FSM states and the AIO classifier.
package dcj11_pkg;

  localparam logic [3:0] AIO_RD_C    = 4'b1100;
  localparam logic [3:0] AIO_RD_B    = 4'b1011;
  localparam logic [3:0] AIO_RD_A    = 4'b1010;
  localparam logic [3:0] AIO_RD_9    = 4'b1001;
  localparam logic [3:0] AIO_RD_8    = 4'b1000;
  localparam logic [3:0] AIO_WR_BYTE = 4'b0011;
  localparam logic [3:0] AIO_WR_WORD = 4'b0001;
  localparam logic [3:0] AIO_GPREAD  = 4'b1110;
  localparam logic [3:0] AIO_GPWRITE = 4'b0101;
  localparam logic [3:0] AIO_INTACK  = 4'b1101;
  localparam logic [3:0] AIO_NONIO   = 4'b1111;

  typedef enum logic [2:0] {
    KIND_NONIO   = 3'd0,
    KIND_READ    = 3'd1,
    KIND_WRITE   = 3'd2,
    KIND_GPREAD  = 3'd3,
    KIND_GPWRITE = 3'd4,
    KIND_INTACK  = 3'd5
  } cyc_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_WAIT = 2'd1,
    ST_OPEN    = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  // Unlisted codes fall through to NONIO so the bus never stalls on them.
  function automatic cyc_kind_e classify(input logic [3:0] aio);
    cyc_kind_e k;
    case (aio)
      AIO_RD_C, AIO_RD_B, AIO_RD_A, AIO_RD_9, AIO_RD_8: k = KIND_READ;
      AIO_WR_BYTE, AIO_WR_WORD:                          k = KIND_WRITE;
      AIO_GPREAD:                                        k = KIND_GPREAD;
      AIO_GPWRITE:                                       k = KIND_GPWRITE;
      AIO_INTACK:                                        k = KIND_INTACK;
      AIO_NONIO:                                         k = KIND_NONIO;
      default:                                           k = KIND_NONIO;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/dcj11_bus_sync_sync_edge.sv
// Multi-stage synchronizer for one active-low strobe; flops reset to the
// inactive level, with single-cycle fall/rise pulses on the synchronized value.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic sys_clk,
  input  logic RESET_n,
  input  logic d_i,
  output logic q_o,
  output logic fall_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge sys_clk) begin
    if (!RESET_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign fall_o = prev_q & ~q_o;
  assign rise_o = ~prev_q & q_o;

endmodule

// File: rtl/dcj11_bus_sync.sv
// DCJ11 bus front end: synchronizes the bus strobes into sys_clk and emits
// single-cycle cycle/read/write events. Optional timeout: DCJ11_BUS_TIMEOUT_EN.
//
//   state    | meaning
//   IDLE     | no cycle open, waiting for ALE_n fall
//   WR_WAIT  | write cycle captured, waiting for SCTL_n fall (data strobe)
//   OPEN     | cycle in progress, waiting for ALE_n rise
//   DRAIN    | cycle timed out, waiting for ALE_n high
module dcj11_bus_sync
  import dcj11_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        sys_clk,
  input  logic        RESET_n,
  input  logic        ale_n_in,
  input  logic        sctl_n_in,
  input  logic        bufctl_n_in,
  input  logic [15:0] dal_in,
  input  logic [3:0]  aio_in,
  output logic        cyc_valid,
  output logic [15:0] cyc_addr,
  output logic [3:0]  cyc_aio,
  output logic [2:0]  cyc_kind,
  output logic        rd_req,
  output logic        wr_req,
  output logic [15:0] wr_data,
  output logic [1:0]  wr_be,
  output logic        busy,
  output logic        dal_drive,
  output logic        timeout_err,
  input  logic        clr_err
);

  logic ale_s, ale_fall, ale_rise;
  logic sctl_s, sctl_fall, sctl_rise;
  logic bufctl_s, bufctl_fall, bufctl_rise;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ale (
    .sys_clk (sys_clk),
    .RESET_n (RESET_n),
    .d_i     (ale_n_in),
    .q_o     (ale_s),
    .fall_o  (ale_fall),
    .rise_o  (ale_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sctl (
    .sys_clk (sys_clk),
    .RESET_n (RESET_n),
    .d_i     (sctl_n_in),
    .q_o     (sctl_s),
    .fall_o  (sctl_fall),
    .rise_o  (sctl_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bufctl (
    .sys_clk (sys_clk),
    .RESET_n (RESET_n),
    .d_i     (bufctl_n_in),
    .q_o     (bufctl_s),
    .fall_o  (bufctl_fall),
    .rise_o  (bufctl_rise)
  );

  // DAL/AIO delayed by the strobe depth so a captured word lines up with the
  // first synchronized low of the strobe that qualifies it.
  logic [SYNC_STAGES-1:0][19:0] dly_q;
  logic [15:0]                  dal_dly;
  logic [3:0]                   aio_dly;

  always_ff @(posedge sys_clk) begin
    if (!RESET_n) begin
      dly_q <= '0;
    end else begin
      dly_q[0] <= {aio_in, dal_in};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign dal_dly = dly_q[SYNC_STAGES-1][15:0];
  assign aio_dly = dly_q[SYNC_STAGES-1][19:16];

  state_e      state_q, state_d;
  cyc_kind_e   new_kind;
  cyc_kind_e   cyc_kind_q, cyc_kind_d;
  logic [15:0] cyc_addr_q, cyc_addr_d;
  logic [3:0]  cyc_aio_q, cyc_aio_d;
  logic        is_word_q, is_word_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [1:0]  wr_be_q, wr_be_d;
  logic        cyc_valid_q, cyc_valid_d;
  logic        rd_req_q, rd_req_d;
  logic        wr_req_q, wr_req_d;
  logic        tmo_hit;
  logic        tmo_fire;

  assign new_kind = classify(aio_dly);

  always_ff @(posedge sys_clk) begin
    if (!RESET_n) begin
      state_q     <= ST_IDLE;
      cyc_kind_q  <= KIND_NONIO;
      cyc_addr_q  <= '0;
      cyc_aio_q   <= '0;
      is_word_q   <= 1'b0;
      wr_data_q   <= '0;
      wr_be_q     <= '0;
      cyc_valid_q <= 1'b0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_kind_q  <= cyc_kind_d;
      cyc_addr_q  <= cyc_addr_d;
      cyc_aio_q   <= cyc_aio_d;
      is_word_q   <= is_word_d;
      wr_data_q   <= wr_data_d;
      wr_be_q     <= wr_be_d;
      cyc_valid_q <= cyc_valid_d;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
    end
  end

  // ALE_n rise closes the cycle even if SCTL_n fell in the same clock.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ale_fall) begin
          state_d = (new_kind == KIND_WRITE) ? ST_WR_WAIT : ST_OPEN;
        end
      end
      ST_WR_WAIT: begin
        if (ale_rise)       state_d = ST_IDLE;
        else if (sctl_fall) state_d = ST_OPEN;
        else if (tmo_hit)   state_d = ST_DRAIN;
      end
      ST_OPEN: begin
        if (ale_rise)     state_d = ST_IDLE;
        else if (tmo_hit) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (ale_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign tmo_fire = (state_d == ST_DRAIN) && (state_q != ST_DRAIN);

  always_comb begin
    cyc_valid_d = 1'b0;
    rd_req_d    = 1'b0;
    wr_req_d    = 1'b0;
    cyc_kind_d  = cyc_kind_q;
    cyc_addr_d  = cyc_addr_q;
    cyc_aio_d   = cyc_aio_q;
    is_word_d   = is_word_q;
    wr_data_d   = wr_data_q;
    wr_be_d     = wr_be_q;
    case (state_q)
      ST_IDLE: begin
        if (ale_fall) begin
          cyc_valid_d = 1'b1;
          rd_req_d    = (new_kind == KIND_READ);
          cyc_kind_d  = new_kind;
          cyc_addr_d  = dal_dly;
          cyc_aio_d   = aio_dly;
          is_word_d   = (aio_dly == AIO_WR_WORD);
        end
      end
      ST_WR_WAIT: begin
        if (sctl_fall) begin
          wr_req_d  = 1'b1;
          wr_data_d = dal_dly;
          wr_be_d   = is_word_q ? 2'b11 : (cyc_addr_q[0] ? 2'b10 : 2'b01);
        end
      end
      default: ;
    endcase
  end

`ifdef DCJ11_BUS_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  // Down-counter spans the whole open cycle, WR_WAIT and OPEN together.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == ST_WR_WAIT || state_q == ST_OPEN) begin
      if (tmo_q != '0) tmo_d = tmo_q - TW'(1);
    end else begin
      tmo_d = TMO_LOAD;
    end
  end

  always_comb begin
    err_d = err_q;
    if (clr_err)  err_d = 1'b0;
    if (tmo_fire) err_d = 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (!RESET_n) begin
      tmo_q <= TMO_LOAD;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign tmo_hit     = (tmo_q == '0);
  assign timeout_err = err_q;

  logic unused_sigs;
  assign unused_sigs = ^{sctl_s, sctl_rise, bufctl_fall, bufctl_rise};
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;

  logic unused_sigs;
  assign unused_sigs = ^{sctl_s, sctl_rise, bufctl_fall, bufctl_rise, clr_err, tmo_fire};
`endif

  assign cyc_valid = cyc_valid_q;
  assign cyc_addr  = cyc_addr_q;
  assign cyc_aio   = cyc_aio_q;
  assign cyc_kind  = cyc_kind_q;
  assign rd_req    = rd_req_q;
  assign wr_req    = wr_req_q;
  assign wr_data   = wr_data_q;
  assign wr_be     = wr_be_q;
  assign busy      = (state_q != ST_IDLE);
  assign dal_drive = ~bufctl_s;

endmodule

// File: tb/tb_dcj11_bus_sync.sv
// Self-checking bench for dcj11_bus_sync: directed bus cycles plus random
// cycles against a cycle-level model of the bus protocol.
module tb_dcj11_bus_sync;

`ifdef DCJ11_BUS_TIMEOUT_EN
  localparam int TB_TMO = 16;
`else
  localparam int TB_TMO = 255;
`endif

  logic        sys_clk = 1'b0;
  logic        RESET_n = 1'b0;
  logic        ale_n = 1'b1, sctl_n = 1'b1, bufctl_n = 1'b1;
  logic [15:0] dal = '0;
  logic [3:0]  aio = '0;
  logic        clr_err = 1'b0;
  logic        cyc_valid, rd_req, wr_req, busy, dal_drive, timeout_err;
  logic [15:0] cyc_addr, wr_data;
  logic [3:0]  cyc_aio;
  logic [2:0]  cyc_kind;
  logic [1:0]  wr_be;

  int tests = 0;
  int fails = 0;

  // Expected kind per AIO code: 0 NONIO, 1 READ, 2 WRITE, 3 GPREAD, 4 GPWRITE, 5 INTACK
  int kind_tab [16] = '{0, 2, 0, 2, 0, 4, 0, 0, 1, 1, 1, 1, 1, 5, 3, 0};

  logic [15:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_aio = '0;
  int          m_kind = 0;
  logic [1:0]  m_be = '0;
  logic        m_err = 1'b0;

  always #5 sys_clk = ~sys_clk;

  dcj11_bus_sync #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TB_TMO)) dut (
    .sys_clk     (sys_clk),
    .RESET_n     (RESET_n),
    .ale_n_in    (ale_n),
    .sctl_n_in   (sctl_n),
    .bufctl_n_in (bufctl_n),
    .dal_in      (dal),
    .aio_in      (aio),
    .cyc_valid   (cyc_valid),
    .cyc_addr    (cyc_addr),
    .cyc_aio     (cyc_aio),
    .cyc_kind    (cyc_kind),
    .rd_req      (rd_req),
    .wr_req      (wr_req),
    .wr_data     (wr_data),
    .wr_be       (wr_be),
    .busy        (busy),
    .dal_drive   (dal_drive),
    .timeout_err (timeout_err),
    .clr_err     (clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_held();
    chk("cyc_addr", cyc_addr, m_addr);
    chk("cyc_aio", cyc_aio, m_aio);
    chk("cyc_kind", cyc_kind, m_kind);
    chk("wr_data", wr_data, m_wdata);
    chk("wr_be", wr_be, m_be);
    chk("timeout_err", timeout_err, m_err);
  endtask

  // One bus cycle. Called right after a negedge; raw changes happen at
  // negedges, tick t is the t-th negedge after ALE_n falls. sctl_at = 0 means
  // SCTL_n never falls; otherwise 1 <= sctl_at < rise_at.
  task automatic run_cycle(input logic [15:0] addr, input logic [3:0] code,
                           input logic [15:0] wdat, input int sctl_at, input int rise_at);
    int k;
    bit is_rd, wr_hit;
    k      = kind_tab[code];
    is_rd  = (k == 1);
    wr_hit = (k == 2) && (sctl_at > 0);
    ale_n = 1'b0;
    dal   = addr;
    aio   = code;
    for (int t = 1; t <= rise_at + 4; t++) begin
      @(negedge sys_clk);
      if (t == 3) begin
        m_addr = addr;
        m_aio  = code;
        m_kind = k;
      end
      if (wr_hit && t == sctl_at + 3) begin
        m_wdata = wdat;
        m_be    = (code == 4'b0001) ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
      end
      chk("cyc_valid", cyc_valid, t == 3);
      chk("rd_req", rd_req, is_rd && t == 3);
      chk("wr_req", wr_req, wr_hit && t == sctl_at + 3);
      chk("busy", busy, t >= 3 && t <= rise_at + 2);
      chk_held();
      if (t == 1) begin
        dal = 16'($urandom);
        aio = 4'($urandom);
      end
      if (t == sctl_at) begin
        sctl_n = 1'b0;
        dal    = wdat;
      end
      if (t == sctl_at + 1) dal = 16'($urandom);
      if (t == rise_at) begin
        ale_n  = 1'b1;
        sctl_n = 1'b1;
      end
    end
  endtask

  task automatic chk_all_zero();
    chk("rst cyc_valid", cyc_valid, 0);
    chk("rst rd_req", rd_req, 0);
    chk("rst wr_req", wr_req, 0);
    chk("rst busy", busy, 0);
    chk("rst cyc_addr", cyc_addr, 0);
    chk("rst cyc_aio", cyc_aio, 0);
    chk("rst cyc_kind", cyc_kind, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst wr_be", wr_be, 0);
    chk("rst dal_drive", dal_drive, 0);
    chk("rst timeout_err", timeout_err, 0);
  endtask

  initial begin
    int sa, ra;
    logic [3:0] code;

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk_all_zero();
    RESET_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk_all_zero();

    // Byte write to 0o177566, low byte
    run_cycle(16'o177566, 4'b0011, 16'h0041, 2, 6);
    // Word write to 0o001001
    run_cycle(16'o001001, 4'b0001, 16'h1234, 1, 5);
    // Byte write to an odd address selects the high byte
    run_cycle(16'o177567, 4'b0011, 16'h4200, 3, 5);
    // Read at 0o177562
    run_cycle(16'o177562, 4'b1001, 16'hbeef, 1, 4);
    // GPREAD at 0
    run_cycle(16'o000000, 4'b1110, 16'h5555, 1, 5);
    // Write aborted by ALE_n rising before SCTL_n
    run_cycle(16'o177570, 4'b0011, 16'h7777, 0, 4);
    // Minimum-length ALE_n pulse
    run_cycle(16'h0abc, 4'b1101, 16'h0000, 0, 1);

    // dal_drive follows BUFCTL_n two clocks late
    bufctl_n = 1'b0;
    @(negedge sys_clk); chk("dal_drive lag1", dal_drive, 0);
    @(negedge sys_clk); chk("dal_drive lag2", dal_drive, 1);
    bufctl_n = 1'b1;
    @(negedge sys_clk); chk("dal_drive hold", dal_drive, 1);
    @(negedge sys_clk); chk("dal_drive off", dal_drive, 0);

    // Random cycles
    for (int i = 0; i < 40; i++) begin
      code = 4'($urandom_range(0, 15));
      if (i % 3 == 0) code = ($urandom_range(0, 1) != 0) ? 4'b0001 : 4'b0011;
      sa = $urandom_range(0, 4);
      ra = sa + $urandom_range(1, 6);
      run_cycle(16'($urandom), code, 16'($urandom), sa, ra);
    end

`ifdef DCJ11_BUS_TIMEOUT_EN
    // ALE_n held low for 40 clocks: timeout after 16 clocks open, DRAIN until rise
    ale_n = 1'b0;
    dal   = 16'h2468;
    aio   = 4'b1001;
    for (int t = 1; t <= 46; t++) begin
      @(negedge sys_clk);
      if (t == 19) m_err = 1'b1;
      chk("tmo cyc_valid", cyc_valid, t == 3);
      chk("tmo busy", busy, t >= 3 && t <= 42);
      chk("tmo timeout_err", timeout_err, m_err);
      if (t == 40) ale_n = 1'b1;
    end
    clr_err = 1'b1;
    @(negedge sys_clk);
    clr_err = 1'b0;
    m_err   = 1'b0;
    chk("tmo clr", timeout_err, m_err);
    @(negedge sys_clk);
    chk("tmo clr hold", timeout_err, m_err);
`endif

    // Reset in the middle of a read cycle, ALE_n still low afterwards
    ale_n = 1'b0;
    dal   = 16'h1357;
    aio   = 4'b1001;
    repeat (5) @(negedge sys_clk);
    chk("mid busy", busy, 1);
    RESET_n = 1'b0;
    dal     = 16'h9bdf;
    @(negedge sys_clk);
    chk_all_zero();
    RESET_n = 1'b1;
    @(negedge sys_clk); chk("recap t1", cyc_valid, 0);
    @(negedge sys_clk); chk("recap t2", cyc_valid, 0);
    @(negedge sys_clk);
    chk("recap cyc_valid", cyc_valid, 1);
    chk("recap rd_req", rd_req, 1);
    chk("recap cyc_addr", cyc_addr, 16'h9bdf);
    chk("recap busy", busy, 1);
    ale_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    chk("recap idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
